wb_arbiter_nx1: RTL and testbench
=================================

Name: wb_arbiter_nx1

Overview:
- Round-robin arbiter that shares one Wishbone initiator port between N_INITIATORS upstream initiators.
- Its output port normally feeds the t_ side of the 1xN address-decoding interconnect.
- Grants are held for the whole bus cycle (t_cyc high), so multi-beat and locked transfers are never interleaved.
- Request/grant is registered; the data path of the granted initiator is combinational.

Parameters:
- ADR_WIDTH, 32, address width.
- DAT_WIDTH, 32, data width; sel width is DAT_WIDTH/8.
- N_INITIATORS, 2, number of upstream initiators (≥2).
- TIMEOUT_CYCLES, 256, watchdog limit; used only with WB_ARB_TIMEOUT_EN.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- t_adr  in  N_INITIATORS*ADR_WIDTH  per-initiator address.
- t_dat_w  in  N_INITIATORS*DAT_WIDTH  per-initiator write data.
- t_dat_r  out  N_INITIATORS*DAT_WIDTH  read data.
- t_cyc, t_stb, t_we  in  N_INITIATORS  per-initiator controls.
- t_sel  in  N_INITIATORS*(DAT_WIDTH/8)  byte selects.
- t_ack, t_err  out  N_INITIATORS  per-initiator responses.
- i_adr  out  ADR_WIDTH  shared initiator address.
- i_dat_w  out  DAT_WIDTH  shared write data.
- i_dat_r  in  DAT_WIDTH  shared read data.
- i_cyc, i_stb, i_we  out  1  shared controls.
- i_sel  out  DAT_WIDTH/8  shared byte selects.
- i_ack, i_err  in  1  shared responses.
- gnt_valid  out  1  a grant is active.
- gnt_idx  out  $clog2(N_INITIATORS)  index of the granted initiator.

Behaviour:
- Clock and reset are fixed as above: single clock `clock`; reset `reset` is asynchronous and active-high.
- Registered state:
  - state: IDLE or BUSY.
  - gnt_idx.
  - last_gnt, reset value N_INITIATORS-1, so initiator 0 wins first.
- Reset values: state=IDLE, gnt_valid=0, gnt_idx=0. Consequently i_cyc=i_stb=0 and all t_ack/t_err=0, with no clock needed.
- IDLE:
  - If any t_cyc[k] is high, pick the first requester scanning last_gnt+1, last_gnt+2, … modulo N_INITIATORS.
  - Next edge: gnt_idx=pick, last_gnt=pick, state=BUSY.
  - Latency from t_cyc rising to i_cyc high is 1 clock.
- BUSY:
  - i_adr, i_dat_w, i_sel, i_we, i_cyc, i_stb mirror initiator gnt_idx combinationally.
  - t_ack[gnt_idx]=i_ack and t_err[gnt_idx]=i_err; all other t_ack/t_err are 0.
  - The grant persists across stb gaps while t_cyc[gnt_idx] stays high.
- Release:
  - When t_cyc[gnt_idx] is low in BUSY, the next edge returns to IDLE.
  - There is exactly one idle cycle between grants, even if others are requesting.
- Outside BUSY:
  - i_cyc=i_stb=0.
  - i_adr/i_dat_w/i_sel/i_we drive initiator 0's values (don't-care to target).
- t_dat_r: i_dat_r is broadcast to every slice.
- Requests that drop while waiting are simply not selected; there is no request latching.
- Simultaneous requests: round-robin as above. Fairness: with all initiators requesting continuously, each gets one grant per N_INITIATORS grants.
- Reset mid-transfer: the grant drops immediately and i_cyc goes low. Any in-flight ack is not forwarded.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - Counter of width $clog2(TIMEOUT_CYCLES)+1 counts cycles in BUSY with i_stb=1 and i_ack=i_err=0.
  - It clears on ack, err, or leaving BUSY.
  - When it reaches TIMEOUT_CYCLES-1, t_err[gnt_idx] is pulsed for one cycle and i_stb is forced low in that cycle.
  - The counter then clears; the grant remains until the initiator drops t_cyc.
- Undefined: no counter; the arbiter waits indefinitely.

Decomposition:
- Shared package wb_arb_pkg holds:
  - state encoding constants (ARB_IDLE=0, ARB_BUSY=1);
  - a grant-index width helper.
- One sub-module, wb_rr_pick: purely combinational; inputs req[N] and last[idx]; outputs pick[idx] and any.

Test Plan:
- Single request: t_cyc[1]=1 at cycle 0 → i_cyc=1 at cycle 1, gnt_idx=1. i_ack pulse returns as t_ack[1] only; t_ack[0]=0.
- Contention, N=2, both t_cyc high from reset → grant order 0,1,0,1. Each grant is held until its t_cyc drops, with one idle cycle between grants.
- Held cycle, 4 beats with stb gaps inside one t_cyc on initiator 0 while initiator 1 requests → initiator 1 is granted only after initiator 0's t_cyc falls.
- Read data: i_dat_r=32'hDEADBEEF with ack → t_dat_r slice 0 and slice 1 both show DEADBEEF; only the granted t_ack is high.
- Async reset asserted mid-BUSY → i_cyc=0 in the same cycle. After release, initiator 0 wins the first arbitration.
- WB_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and the target never acking → t_err[gnt] pulses on the 8th stb cycle; the grant is retained until t_cyc drops.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the N:1 Wishbone round-robin arbiter.
//   arb_state_e   : arbiter state encoding (ARB_IDLE = 0, ARB_BUSY = 1)
//   gnt_idx_width : bit width of a grant index for n initiators
package wb_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Never narrower than one bit so a degenerate n still yields a legal vector.
  function automatic int unsigned gnt_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker.
//   req  : request vector, one bit per initiator
//   last : index granted most recently
//   pick : first requester found scanning last+1, last+2, ... modulo N
//   any  : at least one request is present
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = gnt_idx_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] last,
  output logic [IdxW-1:0] pick,
  output logic            any
);

  logic [IdxW-1:0] cand;

  // Walk the scan order backwards so the closest requester after last overwrites the rest.
  always_comb begin
    pick = '0;
    cand = '0;
    any  = |req;
    for (int off = int'(N); off > 0; off--) begin
      cand = IdxW'((int'(last) + off) % int'(N));
      if (req[cand]) pick = cand;
    end
  end

endmodule

// File: rtl/wb_arbiter_nx1.sv
// Round-robin arbiter sharing one Wishbone initiator port among N_INITIATORS upstream initiators.
// A grant is held for the whole bus cycle (t_cyc high); one idle cycle separates grants.
//   clock, reset              : single clock, asynchronous active-high reset
//   t_adr/t_dat_w/t_sel       : per-initiator request payload (packed slices)
//   t_cyc/t_stb/t_we          : per-initiator controls
//   t_dat_r/t_ack/t_err       : per-initiator responses (read data broadcast)
//   i_adr/i_dat_w/i_sel       : shared initiator payload
//   i_cyc/i_stb/i_we          : shared initiator controls
//   i_dat_r/i_ack/i_err       : shared target responses
//   gnt_valid/gnt_idx         : grant status
// Optional: define WB_ARB_TIMEOUT_EN to enable the stalled-strobe watchdog (TIMEOUT_CYCLES).
module wb_arbiter_nx1
  import wb_arb_pkg::*;
#(
  parameter int unsigned ADR_WIDTH      = 32,
  parameter int unsigned DAT_WIDTH      = 32,
  parameter int unsigned N_INITIATORS   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [N_INITIATORS*ADR_WIDTH-1:0]      t_adr,
  input  logic [N_INITIATORS*DAT_WIDTH-1:0]      t_dat_w,
  output logic [N_INITIATORS*DAT_WIDTH-1:0]      t_dat_r,
  input  logic [N_INITIATORS-1:0]                t_cyc,
  input  logic [N_INITIATORS-1:0]                t_stb,
  input  logic [N_INITIATORS-1:0]                t_we,
  input  logic [N_INITIATORS*(DAT_WIDTH/8)-1:0]  t_sel,
  output logic [N_INITIATORS-1:0]                t_ack,
  output logic [N_INITIATORS-1:0]                t_err,
  output logic [ADR_WIDTH-1:0]                   i_adr,
  output logic [DAT_WIDTH-1:0]                   i_dat_w,
  input  logic [DAT_WIDTH-1:0]                   i_dat_r,
  output logic                                   i_cyc,
  output logic                                   i_stb,
  output logic                                   i_we,
  output logic [DAT_WIDTH/8-1:0]                 i_sel,
  input  logic                                   i_ack,
  input  logic                                   i_err,
  output logic                                   gnt_valid,
  output logic [gnt_idx_width(N_INITIATORS)-1:0] gnt_idx
);

  localparam int unsigned SelW = DAT_WIDTH / 8;
  localparam int unsigned IdxW = gnt_idx_width(N_INITIATORS);

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] gnt_idx_q, gnt_idx_d;
  logic [IdxW-1:0] last_gnt_q, last_gnt_d;
  logic [IdxW-1:0] pick;
  logic [IdxW-1:0] sel_idx;
  logic            any_req;
  logic            busy;
  logic            cyc_gnt;
  logic            stb_gnt;
  logic            to_hit;

  wb_rr_pick #(
    .N    (N_INITIATORS),
    .IdxW (IdxW)
  ) u_pick (
    .req  (t_cyc),
    .last (last_gnt_q),
    .pick (pick),
    .any  (any_req)
  );

  assign busy      = (state_q == ARB_BUSY);
  assign cyc_gnt   = t_cyc[gnt_idx_q];
  assign stb_gnt   = t_stb[gnt_idx_q];
  assign gnt_valid = busy;
  assign gnt_idx   = gnt_idx_q;
  assign t_dat_r   = {N_INITIATORS{i_dat_r}};

  // last_gnt resets to the top index so initiator 0 wins the first arbitration.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      gnt_idx_q  <= '0;
      last_gnt_q <= IdxW'(N_INITIATORS - 1);
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    last_gnt_d = last_gnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          state_d    = ARB_BUSY;
          gnt_idx_d  = pick;
          last_gnt_d = pick;
        end
      end
      ARB_BUSY: begin
        if (!cyc_gnt) state_d = ARB_IDLE;
      end
    endcase
  end

  // Payload follows the granted initiator; outside a grant initiator 0 is steered through.
  always_comb begin
    sel_idx = busy ? gnt_idx_q : '0;
    i_adr   = '0;
    i_dat_w = '0;
    i_sel   = '0;
    i_we    = 1'b0;
    for (int k = 0; k < int'(N_INITIATORS); k++) begin
      if (sel_idx == IdxW'(k)) begin
        i_adr   = t_adr[k*ADR_WIDTH +: ADR_WIDTH];
        i_dat_w = t_dat_w[k*DAT_WIDTH +: DAT_WIDTH];
        i_sel   = t_sel[k*SelW +: SelW];
        i_we    = t_we[k];
      end
    end
    i_cyc = busy & cyc_gnt;
    i_stb = busy & stb_gnt & ~to_hit;
    t_ack = '0;
    t_err = '0;
    if (busy) begin
      t_ack[gnt_idx_q] = i_ack & ~to_hit;
      t_err[gnt_idx_q] = i_err | to_hit;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CntW-1:0] to_cnt_q, to_cnt_d;

  // Counts stalled strobe cycles; the watchdog fires on the last one and restarts.
  always_comb begin
    to_hit   = busy & stb_gnt & (to_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    to_cnt_d = to_cnt_q;
    if (!busy || i_ack || i_err || to_hit) begin
      to_cnt_d = '0;
    end else if (stb_gnt) begin
      to_cnt_d = to_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_timeout;

  assign to_hit         = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_wb_arbiter_nx1.sv
// Self-checking bench for wb_arbiter_nx1: directed scenarios plus a randomized run
// compared against a behavioural round-robin model.
module tb_wb_arbiter_nx1;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned N  = 2;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 8;
  localparam int unsigned IW = 1;

  logic              clock = 1'b0;
  logic              reset;
  logic [N*AW-1:0]   t_adr;
  logic [N*DW-1:0]   t_dat_w;
  logic [N*DW-1:0]   t_dat_r;
  logic [N-1:0]      t_cyc, t_stb, t_we, t_ack, t_err;
  logic [N*SW-1:0]   t_sel;
  logic [AW-1:0]     i_adr;
  logic [DW-1:0]     i_dat_w, i_dat_r;
  logic              i_cyc, i_stb, i_we, i_ack, i_err;
  logic [SW-1:0]     i_sel;
  logic              gnt_valid;
  logic [IW-1:0]     gnt_idx;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  wb_arbiter_nx1 #(
    .ADR_WIDTH      (AW),
    .DAT_WIDTH      (DW),
    .N_INITIATORS   (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .t_adr     (t_adr),
    .t_dat_w   (t_dat_w),
    .t_dat_r   (t_dat_r),
    .t_cyc     (t_cyc),
    .t_stb     (t_stb),
    .t_we      (t_we),
    .t_sel     (t_sel),
    .t_ack     (t_ack),
    .t_err     (t_err),
    .i_adr     (i_adr),
    .i_dat_w   (i_dat_w),
    .i_dat_r   (i_dat_r),
    .i_cyc     (i_cyc),
    .i_stb     (i_stb),
    .i_we      (i_we),
    .i_sel     (i_sel),
    .i_ack     (i_ack),
    .i_err     (i_err),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    t_adr = '0; t_dat_w = '0; t_cyc = '0; t_stb = '0; t_we = '0; t_sel = '0;
    i_dat_r = '0; i_ack = 1'b0; i_err = 1'b0;
  endtask

  // Leaves the bench 1 time unit after a rising edge with the arbiter idle.
  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    @(posedge clock);
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    t_cyc = '1; t_stb = '1; i_ack = 1'b1; i_err = 1'b1;
    #1;
    vectors++;
    if ({gnt_valid, gnt_idx, i_cyc, i_stb, t_ack, t_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_no_clock got valid=%b idx=%0d cyc=%b stb=%b ack=%b err=%b want all 0",
               gnt_valid, gnt_idx, i_cyc, i_stb, t_ack, t_err);
    end
    tick();
    vectors++;
    if ({gnt_valid, gnt_idx, i_cyc, i_stb, t_ack, t_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_held got valid=%b idx=%0d cyc=%b stb=%b ack=%b err=%b want all 0",
               gnt_valid, gnt_idx, i_cyc, i_stb, t_ack, t_err);
    end
    clear_inputs();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    apply_reset();
    t_cyc = 2'b10; t_stb = 2'b10; t_adr[AW +: AW] = 32'h0000_1234;
    #1;
    vectors++;
    if (i_cyc !== 1'b0) begin
      miscompares++;
      $display("FAIL single_cycle0 got i_cyc=%b want 0", i_cyc);
    end
    tick();
    vectors++;
    if ({i_cyc, gnt_valid, gnt_idx, i_adr} !== {1'b1, 1'b1, 1'b1, 32'h0000_1234}) begin
      miscompares++;
      $display("FAIL single_grant got cyc=%b valid=%b idx=%0d adr=%h want 1 1 1 00001234",
               i_cyc, gnt_valid, gnt_idx, i_adr);
    end
    i_ack = 1'b1;
    #1;
    vectors++;
    if (t_ack !== 2'b10) begin
      miscompares++;
      $display("FAIL single_ack got t_ack=%b want 10", t_ack);
    end
    tick();
    i_ack = 1'b0; t_cyc = '0; t_stb = '0;
    tick();
    vectors++;
    if (gnt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_release got gnt_valid=%b want 0", gnt_valid);
    end
  endtask

  task automatic test_contention();
    int exp;
    apply_reset();
    t_cyc = 2'b11; t_stb = 2'b11;
    tick();
    for (int g = 0; g < 4; g++) begin
      exp = g % 2;
      vectors++;
      if ({gnt_valid, gnt_idx} !== {1'b1, IW'(exp)}) begin
        miscompares++;
        $display("FAIL contention_grant%0d got valid=%b idx=%0d want 1 %0d", g, gnt_valid, gnt_idx, exp);
      end
      tick();
      vectors++;
      if ({gnt_valid, gnt_idx} !== {1'b1, IW'(exp)}) begin
        miscompares++;
        $display("FAIL contention_hold%0d got valid=%b idx=%0d want 1 %0d", g, gnt_valid, gnt_idx, exp);
      end
      t_cyc[exp] = 1'b0;
      tick();
      vectors++;
      if (gnt_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL contention_idle%0d got gnt_valid=%b want 0", g, gnt_valid);
      end
      t_cyc[exp] = 1'b1;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_held();
    apply_reset();
    t_cyc = 2'b01;
    tick();
    t_cyc = 2'b11;
    for (int b = 0; b < 4; b++) begin
      t_stb = 2'b01; i_ack = 1'b1;
      #1;
      vectors++;
      if ({gnt_valid, gnt_idx, i_stb, t_ack} !== {1'b1, 1'b0, 1'b1, 2'b01}) begin
        miscompares++;
        $display("FAIL held_beat%0d got valid=%b idx=%0d stb=%b ack=%b want 1 0 1 01",
                 b, gnt_valid, gnt_idx, i_stb, t_ack);
      end
      tick();
      t_stb = 2'b00; i_ack = 1'b0;
      #1;
      vectors++;
      if ({gnt_valid, gnt_idx, i_cyc, i_stb} !== {1'b1, 1'b0, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL held_gap%0d got valid=%b idx=%0d cyc=%b stb=%b want 1 0 1 0",
                 b, gnt_valid, gnt_idx, i_cyc, i_stb);
      end
      tick();
    end
    t_cyc = 2'b10;
    tick();
    vectors++;
    if (gnt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL held_idle got gnt_valid=%b want 0", gnt_valid);
    end
    tick();
    vectors++;
    if ({gnt_valid, gnt_idx} !== {1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL held_next got valid=%b idx=%0d want 1 1", gnt_valid, gnt_idx);
    end
    clear_inputs();
  endtask

  task automatic test_read_data();
    apply_reset();
    t_cyc = 2'b10; t_stb = 2'b10;
    tick();
    i_dat_r = 32'hDEAD_BEEF; i_ack = 1'b1;
    #1;
    vectors++;
    if ({t_dat_r, t_ack} !== {32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b10}) begin
      miscompares++;
      $display("FAIL read_data got dat_r=%h ack=%b want deadbeefdeadbeef 10", t_dat_r, t_ack);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_async_reset();
    apply_reset();
    t_cyc = 2'b10; t_stb = 2'b10;
    tick();
    t_cyc = 2'b11; t_stb = 2'b11; i_ack = 1'b1;
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({i_cyc, i_stb, gnt_valid, t_ack} !== '0) begin
      miscompares++;
      $display("FAIL async_reset got cyc=%b stb=%b valid=%b ack=%b want all 0",
               i_cyc, i_stb, gnt_valid, t_ack);
    end
    tick();
    reset = 1'b0; i_ack = 1'b0;
    tick();
    vectors++;
    if ({gnt_valid, gnt_idx} !== {1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset_first got valid=%b idx=%0d want 1 0", gnt_valid, gnt_idx);
    end
    clear_inputs();
    tick();
  endtask

  // Model: owner = granted initiator or -1; grants scan last+1.. modulo N; release on t_cyc drop.
  task automatic test_random();
    int owner, last, gidx, cnt, si;
    logic busy, hit;
    logic [AW-1:0] adr_a [N];
    logic [DW-1:0] dat_a [N];
    logic [SW-1:0] sel_a [N];
    logic [N-1:0] e_ack, e_err;
    apply_reset();
    owner = -1; last = N - 1; gidx = 0; cnt = 0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(3) == 0) t_cyc[k] = ~t_cyc[k];
        adr_a[k] = $urandom; dat_a[k] = $urandom; sel_a[k] = SW'($urandom);
        t_adr[k*AW +: AW] = adr_a[k];
        t_dat_w[k*DW +: DW] = dat_a[k];
        t_sel[k*SW +: SW] = sel_a[k];
      end
      t_stb = N'($urandom); t_we = N'($urandom);
      i_dat_r = $urandom;
      i_ack = ($urandom_range(1) == 0);
      i_err = ($urandom_range(7) == 0);
      #1;
      busy = (owner >= 0);
      si = busy ? owner : 0;
      hit = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
      hit = busy && t_stb[si] && (cnt == TO - 1);
`endif
      e_ack = '0; e_err = '0;
      if (busy) begin
        e_ack[si] = i_ack && !hit;
        e_err[si] = i_err || hit;
      end
      vectors++;
      if ({gnt_valid, gnt_idx, i_cyc, i_stb, i_we} !==
          {busy, IW'(gidx), busy && t_cyc[si], busy && t_stb[si] && !hit, t_we[si]}) begin
        miscompares++;
        $display("FAIL random_ctrl c=%0d got valid=%b idx=%0d cyc=%b stb=%b we=%b want %b %0d %b %b %b",
                 c, gnt_valid, gnt_idx, i_cyc, i_stb, i_we, busy, gidx,
                 busy && t_cyc[si], busy && t_stb[si] && !hit, t_we[si]);
      end
      vectors++;
      if ({i_adr, i_dat_w, i_sel} !== {adr_a[si], dat_a[si], sel_a[si]}) begin
        miscompares++;
        $display("FAIL random_data c=%0d got %h %h %h want %h %h %h",
                 c, i_adr, i_dat_w, i_sel, adr_a[si], dat_a[si], sel_a[si]);
      end
      vectors++;
      if ({t_ack, t_err, t_dat_r} !== {e_ack, e_err, i_dat_r, i_dat_r}) begin
        miscompares++;
        $display("FAIL random_resp c=%0d got ack=%b err=%b dat_r=%h want %b %b %h",
                 c, t_ack, t_err, t_dat_r, e_ack, e_err, i_dat_r);
      end
      if (!busy || i_ack || i_err || hit) cnt = 0;
      else if (t_stb[si]) cnt++;
      if (busy) begin
        if (!t_cyc[si]) owner = -1;
      end else begin
        for (int off = 1; off <= N; off++) begin
          if (owner < 0 && t_cyc[(last + off) % N]) begin
            owner = (last + off) % N;
            last  = owner;
            gidx  = owner;
          end
        end
      end
      tick();
    end
    clear_inputs();
    tick();
    tick();
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    t_cyc = 2'b01; t_stb = 2'b01;
    tick();
    for (int s = 1; s < TO; s++) begin
      vectors++;
      if ({t_err, i_stb} !== {2'b00, 1'b1}) begin
        miscompares++;
        $display("FAIL timeout_wait%0d got err=%b stb=%b want 00 1", s, t_err, i_stb);
      end
      tick();
    end
    vectors++;
    if ({t_err, i_stb, gnt_valid} !== {2'b01, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL timeout_fire got err=%b stb=%b valid=%b want 01 0 1", t_err, i_stb, gnt_valid);
    end
    tick();
    vectors++;
    if ({t_err, i_stb, gnt_valid, gnt_idx} !== {2'b00, 1'b1, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL timeout_retain got err=%b stb=%b valid=%b idx=%0d want 00 1 1 0",
               t_err, i_stb, gnt_valid, gnt_idx);
    end
    t_cyc = '0; t_stb = '0;
    tick();
    vectors++;
    if (gnt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_release got gnt_valid=%b want 0", gnt_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_held();
    test_read_data();
    test_async_reset();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
